clk_enable_gen: RTL and testbench



---
 rtl/clk_enable_gen_if.sv | 24 ++
 rtl/clk_enable_gen.sv | 197 +++++++++++++++++++
 tb/tb_clk_enable_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_enable_gen_if.sv
// Configuration write channel of clk_enable_gen: a valid/ready handshake
// that carries a target channel index plus a new divider and phase.
interface clk_enable_gen_if #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/clk_enable_gen.sv
// Clock-enable and reset sequencer on the fast PLL clock. Waits for a stable,
// filtered PLL lock, holds downstream reset for a fixed time, then emits
// NUM_CH phase-aligned enable strobes whose divider and phase can be changed
// at runtime. New settings wait in shadow registers until the channel wraps,
// so a strobe period is never cut short.
module clk_enable_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int LOCK_FILTER = 4,
  parameter int RESET_HOLD  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              resync,
  clk_enable_gen_if.slave   cfg,
  output logic [NUM_CH-1:0] ce,
  output logic              rst_out,
  output logic              running
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [DIV_W-1:0]  DEF_DIV   = DIV_W'(DEFAULT_DIV);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOCK_FILTER);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

  // Live settings, counter and shadow (pending) settings of one channel.
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] sh_div;
    logic [DIV_W-1:0] sh_phase;
    logic             pending;
  } chan_t;

  localparam chan_t CHAN_RST = '{
    div: DEF_DIV, phase: '0, cnt: '0, sh_div: DEF_DIV, sh_phase: '0, pending: 1'b0
  };

  state_t            state_q;
  logic [1:0]        sync_q;
  logic [FILT_W-1:0] filt_q;
  logic [HOLD_W-1:0] hold_q;
  logic              lock_ok;
  logic              enter_run;
  logic              in_run;
  logic              realign;
  logic              ready;
  logic              wr_en;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] ce_d;
  chan_t             chan_q [NUM_CH];
  chan_t             chan_d [NUM_CH];

  // Counter start point after a realignment: the phase, unless it does not fit.
  function automatic logic [DIV_W-1:0] start_of(input logic [DIV_W-1:0] d,
                                                input logic [DIV_W-1:0] p);
    return (p < d) ? p : '0;
  endfunction

  // Synchronise raw LOCK and count how long it has been continuously high.
  // NOTE: every clocked register uses <= so all flops see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b00;
      filt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      if (!sync_q[1]) begin
        filt_q <= '0;
      end else if (filt_q != FILT_MAX) begin
        filt_q <= filt_q + FILT_W'(1);
      end
    end
  end

  assign lock_ok = (filt_q >= FILT_MAX);

  // Sequencer: wait for lock, hold downstream reset, then run; outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      hold_q  <= '0;
      rst_out <= 1'b1;
      running <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_ok) begin
            state_q <= HOLD;
            hold_q  <= '0;
          end
        end
        HOLD: begin
          if (!lock_ok) begin
            state_q <= WAIT_LOCK;
          end else if (hold_q == HOLD_LAST) begin
            state_q <= RUN;
            rst_out <= 1'b0;
            running <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        RUN: begin
          if (!lock_ok) begin
            state_q <= WAIT_LOCK;
            rst_out <= 1'b1;
            running <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          rst_out <= 1'b1;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Realignment events and the configuration handshake.
  // NOTE: each signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    enter_run = (state_q == HOLD) && lock_ok && (hold_q == HOLD_LAST);
    in_run    = (state_q == RUN) && lock_ok;
    realign   = enter_run || (in_run && resync);
    ready     = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) ready = !chan_q[i].pending;
    end
    wr_en = cfg.cfg_valid && ready;
  end

  assign cfg.cfg_ready = ready;

  // Per-channel next state: counting, strobe generation and update application.
  always_comb begin
    chan_d = chan_q;
    ce_d   = '0;
    apply  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (realign) begin
        // A realignment restarts every counter and emits no strobe this cycle.
        apply[i]      = chan_q[i].pending;
        chan_d[i].cnt = start_of(chan_q[i].div, chan_q[i].phase);
      end else if (in_run) begin
        if (chan_q[i].div >= DIV_W'(2)) begin
          if (chan_q[i].cnt == chan_q[i].div - DIV_W'(1)) begin
            ce_d[i]       = 1'b1;
            chan_d[i].cnt = '0;
            apply[i]      = chan_q[i].pending;
          end else begin
            chan_d[i].cnt = chan_q[i].cnt + DIV_W'(1);
          end
        end else begin
          ce_d[i]  = (chan_q[i].div == DIV_W'(1));
          apply[i] = chan_q[i].pending;
        end
      end else if (state_q != RUN) begin
        apply[i] = chan_q[i].pending;
      end

      if (apply[i]) begin
        chan_d[i].div     = chan_q[i].sh_div;
        chan_d[i].phase   = chan_q[i].sh_phase;
        chan_d[i].cnt     = start_of(chan_q[i].sh_div, chan_q[i].sh_phase);
        chan_d[i].pending = 1'b0;
      end

      // A write only lands on a non-pending channel, so it never races an apply.
      if (wr_en && (cfg.cfg_ch == CH_W'(i))) begin
        chan_d[i].sh_div   = cfg.cfg_div;
        chan_d[i].sh_phase = cfg.cfg_phase;
        chan_d[i].pending  = 1'b1;
      end
    end
  end

  // Channel registers and the registered strobes.
  // NOTE: the channel array is reset in full because reset must restore every
  // divider to its default and drop any pending update.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) chan_q[i] <= CHAN_RST;
      ce <= '0;
    end else begin
      chan_q <= chan_d;
      ce     <= ce_d;
    end
  end
endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen. A timestamp-based reference model
// (lock window over raw samples, absolute hold deadline, strobe times from
// modular arithmetic on an anchor edge) predicts every output each cycle.
module tb_clk_enable_gen;
  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 4;
  localparam int LOCK_FILTER = 4;
  localparam int RESET_HOLD  = 16;
  localparam int CH_W        = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              pll_locked;
  logic              resync;
  logic [NUM_CH-1:0] ce;
  logic              rst_out;
  logic              running;

  int total = 0;
  int bad   = 0;

  clk_enable_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_bus ();

  clk_enable_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV),
    .LOCK_FILTER(LOCK_FILTER), .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .resync(resync),
    .cfg(cfg_bus), .ce(ce), .rst_out(rst_out), .running(running)
  );

  always #5 clock = ~clock;

  // Reference model state.
  typedef enum {M_WAIT, M_HOLD, M_RUN} mstate_t;
  mstate_t           m_state;
  int                e = 0;
  int                m_hold_start;
  logic [31:0]       hist;
  bit                m_lock;
  int                m_div [NUM_CH];
  int                m_ph [NUM_CH];
  int                m_sdiv [NUM_CH];
  int                m_sph [NUM_CH];
  int                m_anchor [NUM_CH];
  int                m_start [NUM_CH];
  bit                m_pend [NUM_CH];
  logic [NUM_CH-1:0] m_ce;
  logic              m_rst_out;
  logic              m_running;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input logic [CH_W-1:0] ch);
    if (int'(ch) >= NUM_CH) return 1'b1;
    return !m_pend[ch];
  endfunction

  // One clock edge of the reference model, fed with the inputs seen at that edge.
  task automatic model_step();
    bit lk, entering, steady, acc, upd, re;
    int c, ch;
    logic [NUM_CH-1:0] nce;
    e++;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i] = DEFAULT_DIV; m_ph[i] = 0; m_pend[i] = 1'b0;
        m_anchor[i] = e; m_start[i] = 0;
      end
      hist = '0; m_lock = 1'b0; m_state = M_WAIT;
      m_ce = '0; m_rst_out = 1'b1; m_running = 1'b0;
    end else begin
      lk       = m_lock;
      acc      = cfg_bus.cfg_valid && m_ready(cfg_bus.cfg_ch);
      ch       = int'(cfg_bus.cfg_ch);
      entering = (m_state == M_HOLD) && lk && (e == m_hold_start + RESET_HOLD);
      steady   = (m_state == M_RUN) && lk;
      re       = entering || (steady && resync);
      nce      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        upd = 1'b0;
        if (re) begin
          upd = m_pend[i];
          m_anchor[i] = e;
          m_start[i]  = (m_ph[i] < m_div[i]) ? m_ph[i] : 0;
        end else if (steady) begin
          if (m_div[i] <= 1) begin
            nce[i] = (m_div[i] == 1);
            upd    = m_pend[i];
          end else begin
            c = (m_start[i] + (e - 1 - m_anchor[i])) % m_div[i];
            if (c == m_div[i] - 1) begin
              nce[i] = 1'b1;
              upd    = m_pend[i];
            end
          end
        end else if (m_state != M_RUN) begin
          upd = m_pend[i];
        end
        if (upd) begin
          m_div[i] = m_sdiv[i]; m_ph[i] = m_sph[i]; m_pend[i] = 1'b0;
          m_anchor[i] = e;
          m_start[i]  = (m_ph[i] < m_div[i]) ? m_ph[i] : 0;
        end
      end
      if (acc && ch < NUM_CH) begin
        m_sdiv[ch] = int'(cfg_bus.cfg_div);
        m_sph[ch]  = int'(cfg_bus.cfg_phase);
        m_pend[ch] = 1'b1;
      end
      case (m_state)
        M_WAIT: if (lk) begin m_state = M_HOLD; m_hold_start = e; end
        M_HOLD: if (!lk) m_state = M_WAIT; else if (entering) m_state = M_RUN;
        default: if (!lk) m_state = M_WAIT;
      endcase
      hist      = {hist[30:0], pll_locked};
      m_lock    = &hist[LOCK_FILTER+1:2];
      m_ce      = nce;
      m_rst_out = (m_state != M_RUN);
      m_running = (m_state == M_RUN);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("ce", ce, m_ce);
    check("rst_out", rst_out, m_rst_out);
    check("running", running, m_running);
    check("cfg_ready", cfg_bus.cfg_ready, m_ready(cfg_bus.cfg_ch));
  endtask

  task automatic cfg_write(input int ch, input int dv, input int ph);
    bit taken;
    int n;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = CH_W'(ch);
    cfg_bus.cfg_div   = DIV_W'(dv);
    cfg_bus.cfg_phase = DIV_W'(ph);
    taken = 1'b0;
    n = 0;
    while (!taken && n < 50) begin
      taken = m_ready(cfg_bus.cfg_ch);
      tick();
      n++;
    end
    cfg_bus.cfg_valid = 1'b0;
    check("cfg_accept", taken, 1'b1);
  endtask

  task automatic wait_running(input int limit, output int cycles);
    cycles = 0;
    while (!running && cycles < limit) begin
      tick();
      cycles++;
    end
    check("run_timeout", running, 1'b1);
  endtask

  initial begin
    int lock_edge, d, first0, first1, n;
    logic [NUM_CH-1:0] seen;
    bit rst_dropped;

    reset = 1'b1; pll_locked = 1'b0; resync = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0;
    cfg_bus.cfg_div = '0; cfg_bus.cfg_phase = '0;
    repeat (3) tick();
    check("reset_ce", ce, '0);
    check("reset_rst_out", rst_out, 1'b1);
    check("reset_running", running, 1'b0);

    // Lock rises: downstream reset released after sync + filter + hold.
    reset = 1'b0; pll_locked = 1'b1;
    lock_edge = e + 1;
    wait_running(100, d);
    d = e - lock_edge;
    check("lock_to_run", (d >= 21 && d <= 23), 1'b1);
    repeat (3) tick();
    check("first_pulse_pre", ce, '0);
    tick();
    check("first_pulse", ce, 3'b111);
    repeat (8) tick();

    // Runtime reconfiguration: ch1 waits for its wrap, ch2 switched off.
    cfg_write(1, 3, 1);
    cfg_bus.cfg_ch = CH_W'(1);
    tick();
    cfg_write(2, 0, 0);
    repeat (12) tick();
    seen = '0;
    repeat (8) begin tick(); seen |= ce; end
    check("ch2_off", seen[2], 1'b0);

    // Resync with new phases: ch0 leads ch1 by two cycles.
    cfg_write(0, 5, 2);
    cfg_write(1, 5, 0);
    n = 0;
    while ((m_pend[0] || m_pend[1]) && n < 20) begin tick(); n++; end
    check("pend_drain", n < 20, 1'b1);
    resync = 1'b1; tick(); resync = 1'b0;
    first0 = -1; first1 = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ce[0] && first0 < 0) first0 = k;
      if (ce[1] && first1 < 0) first1 = k;
    end
    check("resync_ch0_first", first0, 3);
    check("resync_ch1_first", first1, 5);

    // A write accepted together with resync is left pending.
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_ch = '0;
    cfg_bus.cfg_div = DIV_W'(3); cfg_bus.cfg_phase = '0;
    resync = 1'b1; tick();
    resync = 1'b0; cfg_bus.cfg_valid = 1'b0;
    check("wr_resync_pending", cfg_bus.cfg_ready, 1'b0);
    repeat (12) tick();

    // Randomised configuration traffic and occasional resync.
    repeat (120) begin
      cfg_bus.cfg_valid = 1'($urandom_range(0, 1));
      cfg_bus.cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_bus.cfg_div   = DIV_W'($urandom_range(0, 6));
      cfg_bus.cfg_phase = DIV_W'($urandom_range(0, 6));
      resync            = ($urandom_range(0, 15) == 0);
      tick();
    end
    cfg_bus.cfg_valid = 1'b0; resync = 1'b0;
    repeat (10) tick();

    // One-cycle lock glitch in RUN forces a full re-sequence.
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    n = 0;
    while (!rst_out && n < 4) begin tick(); n++; end
    check("glitch_exit", rst_out, 1'b1);
    check("glitch_running", running, 1'b0);
    wait_running(100, d);
    check("glitch_resequence", d >= LOCK_FILTER + RESET_HOLD, 1'b1);
    repeat (6) tick();

    // Lock toggles during HOLD; reset output must never drop meanwhile.
    pll_locked = 1'b0; repeat (6) tick();
    pll_locked = 1'b1;
    rst_dropped = 1'b0;
    repeat (12) begin tick(); rst_dropped |= !rst_out; end
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    repeat (8) begin tick(); rst_dropped |= !rst_out; end
    check("hold_no_release", rst_dropped, 1'b0);
    cfg_bus.cfg_ch = CH_W'(3);
    tick();
    check("ch3_ready", cfg_bus.cfg_ready, 1'b1);
    cfg_write(3, 1, 0);
    wait_running(100, d);
    repeat (12) tick();

    // Reset mid-RUN with updates pending.
    cfg_write(0, 7, 3);
    cfg_write(1, 6, 1);
    cfg_bus.cfg_ch = '0;
    reset = 1'b1; tick();
    check("midrst_ce", ce, '0);
    check("midrst_rst_out", rst_out, 1'b1);
    check("midrst_running", running, 1'b0);
    check("midrst_ready", cfg_bus.cfg_ready, 1'b1);
    reset = 1'b0;
    wait_running(100, d);
    repeat (3) tick();
    tick();
    check("midrst_default_div", ce, 3'b111);
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
